// File: rtl/unary_add_arbiter.sv
// rtl/unary_add_arbiter.sv - round-robin scheduler sharing one serial 2-bit unary adder
module unary_add_arbiter #(
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] opa,
    input  logic [2*NREQ-1:0] opb,
    output logic [NREQ-1:0]   ack,
    output logic [2:0]        res,
    output logic              busy,
    output logic              adder_rst_n,
    output logic              adder_en,
    output logic              adder_rw,
    output logic              adder_A,
    output logic              adder_B,
    input  logic              adder_dout,
    input  logic              adder_C
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_WRITE,
        S_DONE
    } state_t;

    state_t         state, state_nx;
    logic [1:0]     step, step_nx;
    logic [IDW-1:0] ptr, id, gnt_id;
    logic           gnt_vld;
    logic [1:0]     opa_q, opb_q, ones_q;
    logic           carry_q;
    int             idx;

    // First waiting requester at or after ptr, wrapping.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        idx     = 0;
        for (int i = 0; i < NREQ; i++) begin
            idx = (int'(ptr) + i) % NREQ;
            if (!gnt_vld && req[idx[IDW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_id  = idx[IDW-1:0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
            step  <= 2'd0;
        end else begin
            state <= state_nx;
            step  <= step_nx;
        end
    end

    always_comb begin
        state_nx = state;
        step_nx  = step;
        adder_en = 1'b0;
        adder_rw = 1'b0;
        adder_A  = 1'b0;
        adder_B  = 1'b0;
        ack      = '0;
        res      = 3'd0;
        case (state)
            S_IDLE: begin
                if (gnt_vld) begin
                    state_nx = S_READ;
                    step_nx  = 2'd0;
                end
            end
            S_READ: begin
                adder_en = 1'b1;
                adder_A  = (opa_q > step);
                adder_B  = (opb_q > step);
                if (step == 2'd2) begin
                    state_nx = S_DRAIN;
                    step_nx  = 2'd0;
                end else begin
                    step_nx = step + 2'd1;
                end
            end
            S_DRAIN: begin
                adder_en = 1'b1;
                state_nx = S_WRITE;
                step_nx  = 2'd0;
            end
            S_WRITE: begin
                adder_en = 1'b1;
                adder_rw = 1'b1;
                if (step == 2'd3) begin
                    state_nx = S_DONE;
                    step_nx  = 2'd0;
                end else begin
                    step_nx = step + 2'd1;
                end
            end
            S_DONE: begin
                ack[id]  = 1'b1;
                res      = {carry_q, ones_q};
                state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr     <= '0;
            id      <= '0;
            opa_q   <= 2'd0;
            opb_q   <= 2'd0;
            carry_q <= 1'b0;
            ones_q  <= 2'd0;
        end else begin
            if (state == S_IDLE && gnt_vld) begin
                id      <= gnt_id;
                opa_q   <= opa[2*int'(gnt_id) +: 2];
                opb_q   <= opb[2*int'(gnt_id) +: 2];
                carry_q <= 1'b0;
                ones_q  <= 2'd0;
            end
            if ((state == S_READ || state == S_DRAIN || state == S_WRITE) && adder_C)
                carry_q <= 1'b1;
            // dout lags each write edge by one cycle, so sample from w=1 up to DONE entry.
            if (state == S_WRITE && step != 2'd0 && adder_dout && ones_q != 2'd3)
                ones_q <= ones_q + 2'd1;
            if (state == S_DONE) begin
                if (id == IDW'(NREQ - 1))
                    ptr <= '0;
                else
                    ptr <= id + IDW'(1);
            end
        end
    end

    assign busy        = (state != S_IDLE);
    assign adder_rst_n = ~rst;

endmodule
